// File: rtl/spi_mpu_bridge_if.sv
// MPU-side bus between the SPI bridge (master) and the graphics core (slave).
// Strobes and byte enables are active low.
interface spi_mpu_bridge_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  _mpu_en;
  logic                  _mpu_rd;
  logic                  _mpu_wr;
  logic [1:0]            _mpu_be;
  logic [ADDR_WIDTH-1:0] mpu_addr;
  logic [DATA_WIDTH-1:0] mpu_data_wr;
  logic [DATA_WIDTH-1:0] mpu_data_rd;

  modport master (
    output _mpu_en, _mpu_rd, _mpu_wr, _mpu_be, mpu_addr, mpu_data_wr,
    input  mpu_data_rd
  );

  modport slave (
    input  _mpu_en, _mpu_rd, _mpu_wr, _mpu_be, mpu_addr, mpu_data_wr,
    output mpu_data_rd
  );
endinterface

// File: rtl/spi_mpu_bridge.sv
// SPI mode-0 slave that turns CMD/ADDR/DATA frames into single-cycle accesses
// on the MPU bus. SCK, SS_n and MOSI are oversampled in the clk domain; burst
// transfers auto-increment the word address. Reads are prefetched one word
// ahead so MISO can start each word on its first falling SCK edge.
module spi_mpu_bridge #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int READ_LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spi_sck,
  input  logic             spi_ss_n,
  input  logic             spi_mosi,
  output logic             spi_miso,
  output logic             spi_miso_oe,
  spi_mpu_bridge_if.master mpu
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_WDATA  = 3'd3,
    ST_WSTRB  = 3'd4,
    ST_RFETCH = 3'd5,
    ST_RDATA  = 3'd6
  } state_t;

  // Receive shifter must hold at least the 16-bit address field.
  localparam int SH_W  = (DATA_WIDTH > 16) ? DATA_WIDTH : 16;
  localparam int CNT_W = $clog2(SH_W) + 1;
  localparam int FC_W  = $clog2(READ_LATENCY + 1) + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(15);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [FC_W-1:0]  RL_LAST   = FC_W'(READ_LATENCY);

  state_t state_r, state_next_s;

  logic [SYNC_STAGES-1:0] sck_sync_r, ss_sync_r, mosi_sync_r;
  logic sck_prev_r, ss_prev_r;
  logic sck_s, ss_s, mosi_s;
  logic sck_rise_s, sck_fall_s, ss_rise_s, ss_fall_s;

  logic [CNT_W-1:0]      bit_cnt_r;
  logic [SH_W-2:0]       rx_r;
  logic [SH_W-1:0]       rx_next_s;
  logic                  cmd_wr_r;
  logic                  shift_state_s;

  logic                  en_r, rd_r, wr_r;
  logic [1:0]            be_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] data_wr_r;

  logic                  fetch_busy_r;
  logic [FC_W-1:0]       fetch_cnt_r;
  logic                  fetch_done_s, fetch_start_s, rd_load_s;
  logic [DATA_WIDTH-1:0] pf_r;
  logic [DATA_WIDTH-1:0] tx_r;
  logic                  miso_r, oe_r;

  // Free-running synchronisers; left unreset so a reset with SS_n already low
  // cannot fabricate a falling edge.
  always_ff @(posedge clk) begin
    sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], spi_sck};
    ss_sync_r   <= {ss_sync_r[SYNC_STAGES-2:0], spi_ss_n};
    mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi};
    sck_prev_r  <= sck_sync_r[SYNC_STAGES-1];
  end

  // SS_n history; reset to "low" so only a fresh high-to-low edge opens a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      ss_prev_r <= 1'b0;
    end else begin
      ss_prev_r <= ss_s;
    end
  end

  assign sck_s      = sck_sync_r[SYNC_STAGES-1];
  assign ss_s       = ss_sync_r[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync_r[SYNC_STAGES-1];
  assign sck_rise_s = sck_s & ~sck_prev_r;
  assign sck_fall_s = ~sck_s & sck_prev_r;
  assign ss_rise_s  = ss_s & ~ss_prev_r;
  assign ss_fall_s  = ~ss_s & ss_prev_r;

  assign rx_next_s     = {rx_r, mosi_s};
  assign shift_state_s = (state_r == ST_CMD) || (state_r == ST_ADDR) || (state_r == ST_WDATA);
  assign fetch_done_s  = fetch_busy_r && (fetch_cnt_r == RL_LAST);
  assign rd_load_s     = (state_r == ST_RDATA) && (state_next_s == ST_RDATA) &&
                         sck_fall_s && (bit_cnt_r == CNT_ZERO);
  assign fetch_start_s = ((state_r == ST_ADDR) && (state_next_s == ST_RFETCH)) || rd_load_s;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; SS_n rising aborts from any state first.
  always_comb begin
    state_next_s = state_r;
    if (ss_rise_s) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (ss_fall_s) state_next_s = ST_CMD;
          else           state_next_s = ST_IDLE;
        end
        ST_CMD: begin
          if (sck_rise_s && (bit_cnt_r == CMD_LAST)) state_next_s = ST_ADDR;
          else                                       state_next_s = ST_CMD;
        end
        ST_ADDR: begin
          if (sck_rise_s && (bit_cnt_r == ADDR_LAST)) begin
            if (cmd_wr_r) state_next_s = ST_WDATA;
            else          state_next_s = ST_RFETCH;
          end else begin
            state_next_s = ST_ADDR;
          end
        end
        ST_WDATA: begin
          if (sck_rise_s && (bit_cnt_r == WORD_LAST)) state_next_s = ST_WSTRB;
          else                                        state_next_s = ST_WDATA;
        end
        ST_WSTRB:  state_next_s = ST_WDATA;
        ST_RFETCH: begin
          if (fetch_done_s) state_next_s = ST_RFETCH == ST_RFETCH ? ST_RDATA : ST_RFETCH;
          else              state_next_s = ST_RFETCH;
        end
        ST_RDATA:  state_next_s = ST_RDATA;
        default:   state_next_s = ST_IDLE;
      endcase
    end
  end

  // Bit counter, receive shifter and command capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_r <= CNT_ZERO;
      rx_r      <= {(SH_W-1){1'b0}};
      cmd_wr_r  <= 1'b0;
    end else begin
      if (state_next_s != state_r) begin
        bit_cnt_r <= CNT_ZERO;
      end else if (shift_state_s && sck_rise_s) begin
        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
      end else if ((state_r == ST_RDATA) && sck_fall_s) begin
        bit_cnt_r <= (bit_cnt_r == WORD_LAST) ? CNT_ZERO : bit_cnt_r + CNT_W'(1);
      end
      if (shift_state_s && sck_rise_s) begin
        rx_r <= rx_next_s[SH_W-2:0];
      end
      if ((state_r == ST_CMD) && sck_rise_s && (bit_cnt_r == CNT_ZERO)) begin
        cmd_wr_r <= mosi_s;
      end
    end
  end

  // MPU bus driver: address load, write strobe and the read-fetch window.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_r         <= 1'b1;
      rd_r         <= 1'b1;
      wr_r         <= 1'b1;
      be_r         <= 2'b11;
      addr_r       <= {ADDR_WIDTH{1'b0}};
      data_wr_r    <= {DATA_WIDTH{1'b0}};
      pf_r         <= {DATA_WIDTH{1'b0}};
      fetch_busy_r <= 1'b0;
      fetch_cnt_r  <= {FC_W{1'b0}};
    end else begin
      if ((state_r == ST_ADDR) && ((state_next_s == ST_WDATA) || (state_next_s == ST_RFETCH))) begin
        addr_r <= ADDR_WIDTH'(rx_next_s[15:0]);
      end
      if (state_next_s == ST_WSTRB) begin
        data_wr_r <= rx_next_s[DATA_WIDTH-1:0];
        en_r      <= 1'b0;
        wr_r      <= 1'b0;
        be_r      <= 2'b00;
      end else if (state_r == ST_WSTRB) begin
        en_r   <= 1'b1;
        wr_r   <= 1'b1;
        be_r   <= 2'b11;
        addr_r <= addr_r + ADDR_WIDTH'(1);
      end
      // A fetch runs to completion even if SS_n rises part-way through.
      if (fetch_start_s) begin
        fetch_busy_r <= 1'b1;
        fetch_cnt_r  <= {FC_W{1'b0}};
        en_r         <= 1'b0;
        rd_r         <= 1'b0;
        be_r         <= 2'b00;
      end else if (fetch_done_s) begin
        fetch_busy_r <= 1'b0;
        en_r         <= 1'b1;
        rd_r         <= 1'b1;
        be_r         <= 2'b11;
        pf_r         <= mpu.mpu_data_rd;
        addr_r       <= addr_r + ADDR_WIDTH'(1);
      end else if (fetch_busy_r) begin
        fetch_cnt_r  <= fetch_cnt_r + FC_W'(1);
      end
    end
  end

  // MISO shifter: load from the prefetch buffer at each word start, shift on SCK falling.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_r   <= {DATA_WIDTH{1'b0}};
      miso_r <= 1'b0;
      oe_r   <= 1'b0;
    end else begin
      oe_r <= (state_next_s == ST_RDATA);
      if (state_next_s != ST_RDATA) begin
        miso_r <= 1'b0;
        tx_r   <= {DATA_WIDTH{1'b0}};
      end else if (rd_load_s) begin
        miso_r <= pf_r[DATA_WIDTH-1];
        tx_r   <= {pf_r[DATA_WIDTH-2:0], 1'b0};
      end else if ((state_r == ST_RDATA) && sck_fall_s) begin
        miso_r <= tx_r[DATA_WIDTH-1];
        tx_r   <= {tx_r[DATA_WIDTH-2:0], 1'b0};
      end
    end
  end

  assign spi_miso        = miso_r;
  assign spi_miso_oe     = oe_r;
  assign mpu._mpu_en     = en_r;
  assign mpu._mpu_rd     = rd_r;
  assign mpu._mpu_wr     = wr_r;
  assign mpu._mpu_be     = be_r;
  assign mpu.mpu_addr    = addr_r;
  assign mpu.mpu_data_wr = data_wr_r;

endmodule

// File: tb/tb_spi_mpu_bridge.sv
// Bench for spi_mpu_bridge: an SPI mode-0 master running at f_clk = 16*f_sck,
// a READ_LATENCY=2 memory model returning addr^0xFFFF, and scoreboards for
// expected bus writes, expected fetch addresses and expected MISO words.
module tb_spi_mpu_bridge;
  localparam int HALF_CLKS = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic spi_sck = 1'b0;
  logic spi_ss_n = 1'b1;
  logic spi_mosi = 1'b0;
  logic spi_miso, spi_miso_oe;

  spi_mpu_bridge_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

  spi_mpu_bridge #(
    .ADDR_WIDTH(16), .DATA_WIDTH(16), .SYNC_STAGES(2), .READ_LATENCY(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .spi_sck     (spi_sck),
    .spi_ss_n    (spi_ss_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .mpu         (bus)
  );

  always #5 clk = ~clk;

  // Memory model: data for the address seen under _mpu_rd appears two clocks later.
  logic [15:0] rd_p0, rd_p1;
  always @(posedge clk) begin
    rd_p0 <= (!bus._mpu_rd) ? (bus.mpu_addr ^ 16'hFFFF) : 16'h0000;
    rd_p1 <= rd_p0;
  end
  assign bus.mpu_data_rd = rd_p1;

  logic [31:0] wr_q[$];
  logic [15:0] fetch_q[$];
  logic [15:0] rdw_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int fetch_cnt = 0;
  int rd_len = 0;
  bit mon_en = 1'b0;

  // Bus monitor: pops expected writes/fetches as the DUT strobes.
  initial begin
    logic prev_wr, prev_rd;
    logic [31:0] exp_w;
    logic [15:0] exp_a;
    prev_wr = 1'b1;
    prev_rd = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (!bus._mpu_wr) begin
          wr_cnt++;
          n_cmp++;
          if (wr_q.size() == 0) begin
            n_err++;
            $display("FAIL wr_unexpected: got addr=%h data=%h, required no write", bus.mpu_addr, bus.mpu_data_wr);
          end else begin
            exp_w = wr_q.pop_front();
            if ({bus.mpu_addr, bus.mpu_data_wr} !== exp_w) begin
              n_err++;
              $display("FAIL wr_addr_data: got %h/%h, required %h/%h", bus.mpu_addr, bus.mpu_data_wr, exp_w[31:16], exp_w[15:0]);
            end
          end
          n_cmp++;
          if ({bus._mpu_en, bus._mpu_be, prev_wr} !== 4'b0001) begin
            n_err++;
            $display("FAIL wr_strobe: got en/be/prev_wr=%b, required 0001", {bus._mpu_en, bus._mpu_be, prev_wr});
          end
        end
        if (!bus._mpu_rd) begin
          if (prev_rd) begin
            fetch_cnt++;
            rd_len = 1;
            n_cmp++;
            if (fetch_q.size() == 0) begin
              n_err++;
              $display("FAIL fetch_unexpected: got addr=%h, required no fetch", bus.mpu_addr);
            end else begin
              exp_a = fetch_q.pop_front();
              if (bus.mpu_addr !== exp_a) begin
                n_err++;
                $display("FAIL fetch_addr: got %h, required %h", bus.mpu_addr, exp_a);
              end
            end
          end else begin
            rd_len++;
          end
        end else if (!prev_rd) begin
          n_cmp++;
          if (rd_len != 3) begin
            n_err++;
            $display("FAIL rd_width: got %0d cycles, required 3", rd_len);
          end
        end
        if (!bus._mpu_rd && !bus._mpu_wr) begin
          n_err++;
          $display("FAIL rd_wr_overlap: got both strobes low, required at most one");
        end
      end
      prev_wr = bus._mpu_wr;
      prev_rd = bus._mpu_rd;
    end
  end

  task automatic half_period();
    repeat (HALF_CLKS) @(posedge clk);
    #1;
  endtask

  // One mode-0 bit: SCK falls and MOSI changes together, MISO sampled at the rise.
  task automatic spi_bit(input logic b, output logic miso_b, output logic oe_b);
    spi_sck  = 1'b0;
    spi_mosi = b;
    half_period();
    miso_b   = spi_miso;
    oe_b     = spi_miso_oe;
    spi_sck  = 1'b1;
    half_period();
  endtask

  task automatic spi_word(input logic [15:0] tx, input int nbits,
                          output logic [15:0] rx, output logic oe_all);
    logic b, o;
    rx = 16'h0000;
    oe_all = 1'b1;
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_bit(tx[i], b, o);
      rx = {rx[14:0], b};
      oe_all = oe_all & o;
    end
  endtask

  task automatic spi_begin();
    spi_ss_n = 1'b0;
    half_period();
  endtask

  // Frame end: SCK returns low in the same instant SS_n rises.
  task automatic spi_end();
    spi_sck  = 1'b0;
    spi_ss_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus._mpu_en, bus._mpu_rd, bus._mpu_wr, bus._mpu_be, spi_miso, spi_miso_oe} !== 7'b1111100) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b, required 1111100", {bus._mpu_en, bus._mpu_rd, bus._mpu_wr, bus._mpu_be, spi_miso, spi_miso_oe});
    end
    n_cmp++;
    if (bus.mpu_addr !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_addr: got %h, required 0000", bus.mpu_addr);
    end
    n_cmp++;
    if (bus.mpu_data_wr !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_data: got %h, required 0000", bus.mpu_data_wr);
    end
    reset = 1'b0;
    mon_en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Runs right after reset with address 0 so every output should read as at reset.
  task automatic test_abort();
    logic [15:0] rx;
    logic oe;
    int w0;
    w0 = wr_cnt;
    spi_begin();
    spi_word(16'h0080, 8, rx, oe);
    spi_word(16'h0000, 16, rx, oe);
    spi_word(16'h01FF, 9, rx, oe);
    spi_end();
    n_cmp++;
    if (wr_cnt - w0 != 0) begin
      n_err++;
      $display("FAIL abort_no_write: got %0d writes, required 0", wr_cnt - w0);
    end
    n_cmp++;
    if ({bus._mpu_en, bus._mpu_rd, bus._mpu_wr, bus._mpu_be, spi_miso, spi_miso_oe, bus.mpu_addr, bus.mpu_data_wr}
        !== {7'b1111100, 16'h0000, 16'h0000}) begin
      n_err++;
      $display("FAIL abort_outputs: got ctrl=%b addr=%h data=%h, required 1111100/0000/0000",
               {bus._mpu_en, bus._mpu_rd, bus._mpu_wr, bus._mpu_be, spi_miso, spi_miso_oe}, bus.mpu_addr, bus.mpu_data_wr);
    end
  endtask

  task automatic test_write_burst(input logic [15:0] addr, input logic [15:0] d0, input logic [15:0] d1);
    logic [15:0] rx;
    logic oe;
    int w0;
    w0 = wr_cnt;
    spi_begin();
    spi_word(16'h0080, 8, rx, oe);
    spi_word(addr, 16, rx, oe);
    wr_q.push_back({addr, d0});
    spi_word(d0, 16, rx, oe);
    wr_q.push_back({addr + 16'h0001, d1});
    spi_word(d1, 16, rx, oe);
    spi_end();
    n_cmp++;
    if (wr_cnt - w0 != 2) begin
      n_err++;
      $display("FAIL write_count: got %0d, required 2", wr_cnt - w0);
    end
    n_cmp++;
    if (wr_q.size() != 0) begin
      n_err++;
      $display("FAIL write_pending: got %0d left, required 0", wr_q.size());
    end
    n_cmp++;
    if ({bus.mpu_addr, bus.mpu_data_wr} !== {addr + 16'h0002, d1}) begin
      n_err++;
      $display("FAIL write_hold: got %h/%h, required %h/%h", bus.mpu_addr, bus.mpu_data_wr, addr + 16'h0002, d1);
    end
  endtask

  // Used both for the plain 2-word burst and the 4-word margin run at 16x.
  task automatic test_read_burst(input logic [15:0] addr, input int nwords);
    logic [15:0] rx, exp_rx;
    logic oe;
    int f0;
    f0 = fetch_cnt;
    for (int i = 0; i <= nwords; i++) fetch_q.push_back(addr + 16'(i));
    for (int i = 0; i < nwords; i++) rdw_q.push_back((addr + 16'(i)) ^ 16'hFFFF);
    spi_begin();
    spi_word(16'h0000, 8, rx, oe);
    spi_word(addr, 16, rx, oe);
    for (int i = 0; i < nwords; i++) begin
      spi_word(16'h0000, 16, rx, oe);
      exp_rx = rdw_q.pop_front();
      n_cmp++;
      if (rx !== exp_rx) begin
        n_err++;
        $display("FAIL read_word%0d: got %h, required %h", i, rx, exp_rx);
      end
      n_cmp++;
      if (oe !== 1'b1) begin
        n_err++;
        $display("FAIL read_oe%0d: got %b, required 1", i, oe);
      end
    end
    spi_end();
    n_cmp++;
    if (fetch_cnt - f0 != nwords + 1) begin
      n_err++;
      $display("FAIL read_fetches: got %0d, required %0d", fetch_cnt - f0, nwords + 1);
    end
    n_cmp++;
    if ({spi_miso_oe, bus._mpu_rd} !== 2'b01) begin
      n_err++;
      $display("FAIL read_idle: got oe/rd=%b, required 01", {spi_miso_oe, bus._mpu_rd});
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] rx;
    logic oe;
    int w0;
    w0 = wr_cnt;
    spi_begin();
    spi_word(16'h0080, 8, rx, oe);
    spi_word(16'h0300, 16, rx, oe);
    spi_word(16'h0018, 5, rx, oe);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({bus._mpu_en, bus._mpu_rd, bus._mpu_wr, bus._mpu_be, spi_miso, spi_miso_oe, bus.mpu_addr, bus.mpu_data_wr}
        !== {7'b1111100, 16'h0000, 16'h0000}) begin
      n_err++;
      $display("FAIL reset_mid_outputs: got ctrl=%b addr=%h data=%h, required 1111100/0000/0000",
               {bus._mpu_en, bus._mpu_rd, bus._mpu_wr, bus._mpu_be, spi_miso, spi_miso_oe}, bus.mpu_addr, bus.mpu_data_wr);
    end
    reset = 1'b0;
    spi_word(16'h07C3, 11, rx, oe);
    spi_end();
    n_cmp++;
    if (wr_cnt - w0 != 0) begin
      n_err++;
      $display("FAIL reset_mid_no_write: got %0d writes, required 0", wr_cnt - w0);
    end
    w0 = wr_cnt;
    spi_begin();
    spi_word(16'h0080, 8, rx, oe);
    spi_word(16'h0400, 16, rx, oe);
    wr_q.push_back({16'h0400, 16'h5A5A});
    spi_word(16'h5A5A, 16, rx, oe);
    spi_end();
    n_cmp++;
    if ((wr_cnt - w0 != 1) || (wr_q.size() != 0)) begin
      n_err++;
      $display("FAIL reset_mid_new_frame: got %0d writes/%0d pending, required 1/0", wr_cnt - w0, wr_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_abort();
    test_write_burst(16'h0010, 16'h1234, 16'hABCD);
    test_read_burst(16'h0200, 2);
    test_write_burst(16'hFFFF, 16'h0F0F, 16'hF0F0);
    test_reset_mid();
    test_read_burst(16'h8000, 4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
